// File: rtl/color_matrix_pkg.sv
// Shared constants, index types and reset helpers for the colour-matrix pipeline.
package color_matrix_pkg;

  localparam int unsigned CFG_AW = 4;
  localparam int unsigned N_COEF = 9;
  localparam int unsigned N_OFFS = 3;
  localparam int unsigned N_CH   = 3;

  typedef logic [CFG_AW-1:0] cfg_addr_t;
  typedef logic [1:0]        offs_idx_t;

  localparam cfg_addr_t CFG_M00 = 4'd0;
  localparam cfg_addr_t CFG_M22 = 4'd8;
  localparam cfg_addr_t CFG_O0  = 4'd9;
  localparam cfg_addr_t CFG_O2  = 4'd11;

  // Identity matrix entry for row-major coefficient index idx: 1.0 on the diagonal.
  function automatic int unsigned identity_value(input int unsigned idx, input int unsigned frac);
    if (idx == 0 || idx == 4 || idx == 8) begin
      return 32'd1 << frac;
    end
    return 32'd0;
  endfunction

endpackage

// File: rtl/cm_channel.sv
// One output channel: three products, sum, round-half-up, offset, clamp and overflow flag.
module cm_channel #(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned MSIZE = 9,
  parameter int unsigned FRAC  = 6,
  parameter int unsigned OSIZE = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [DSIZE-1:0]        x0,
  input  logic [DSIZE-1:0]        x1,
  input  logic [DSIZE-1:0]        x2,
  input  logic signed [MSIZE-1:0] c0,
  input  logic signed [MSIZE-1:0] c1,
  input  logic signed [MSIZE-1:0] c2,
  input  logic signed [OSIZE-1:0] off,
  output logic [DSIZE-1:0]        res,
  output logic                    ovf
);

  localparam int unsigned PW = DSIZE + MSIZE + 1;
  localparam int unsigned AW = PW + 2;
  localparam int unsigned SW = ((AW > OSIZE) ? AW : OSIZE) + 1;
  localparam logic signed [AW-1:0] HALF = AW'(1) << (FRAC - 1);
  localparam logic signed [SW-1:0] MAXV = $signed(SW'({DSIZE{1'b1}}));

  logic signed [PW-1:0]    p0, p1, p2;
  logic signed [OSIZE-1:0] off2;
  logic signed [AW-1:0]    acc;
  logic signed [AW-1:0]    rnd;
  logic signed [SW-1:0]    sum_c;
  logic signed [SW-1:0]    sum3;

  // Unsigned pixel times signed coefficient, both widened to the product width first.
  function automatic logic signed [PW-1:0] mul(input logic [DSIZE-1:0] x,
                                               input logic signed [MSIZE-1:0] c);
    logic signed [PW-1:0] xs;
    logic signed [PW-1:0] cs;
    xs = {{(PW-DSIZE){1'b0}}, x};
    cs = {{(PW-MSIZE){c[MSIZE-1]}}, c};
    return xs * cs;
  endfunction

  // Stage 2: products
  always_ff @(posedge clk) begin
    if (en) begin
      p0   <= mul(x0, c0);
      p1   <= mul(x1, c1);
      p2   <= mul(x2, c2);
      off2 <= off;
    end
  end

  // Stage 3: full-precision sum, round half up, add integer offset
  always_comb begin
    acc   = {{2{p0[PW-1]}}, p0} + {{2{p1[PW-1]}}, p1} + {{2{p2[PW-1]}}, p2};
    rnd   = (acc + HALF) >>> FRAC;
    sum_c = SW'(rnd) + SW'(off2);
  end

  always_ff @(posedge clk) begin
    if (en) begin
      sum3 <= sum_c;
    end
  end

  // Stage 4: clamp to the unsigned pixel range and flag saturation
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res <= '0;
      ovf <= 1'b0;
    end else if (en) begin
      if (sum3[SW-1]) begin
        res <= '0;
        ovf <= 1'b1;
      end else if (sum3 > MAXV) begin
        res <= '1;
        ovf <= 1'b1;
      end else begin
        res <= sum3[DSIZE-1:0];
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/color_matrix_pipe.sv
// 3x3 colour matrix with offsets, 4-stage stallable pipeline, double-buffered frame-synchronous config.
module color_matrix_pipe
  import color_matrix_pkg::*;
#(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned MSIZE = 9,
  parameter int unsigned FRAC  = 6,
  parameter int unsigned OSIZE = 10,
  localparam int unsigned CW   = (MSIZE > OSIZE) ? MSIZE : OSIZE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_sof,
  input  logic [DSIZE-1:0]  iR,
  input  logic [DSIZE-1:0]  iG,
  input  logic [DSIZE-1:0]  iB,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_sof,
  output logic [DSIZE-1:0]  Ro,
  output logic [DSIZE-1:0]  Go,
  output logic [DSIZE-1:0]  Bo,
  output logic [2:0]        ovf,
  input  logic              cfg_we,
  input  logic [CFG_AW-1:0] cfg_addr,
  input  logic [CW-1:0]     cfg_wdata,
  input  logic              cfg_commit,
  output logic              cfg_pending
);

  logic en;
  logic accept;
  logic transfer;
  logic pending;

  logic [MSIZE-1:0]        shd_m [N_COEF];
  logic [MSIZE-1:0]        act_m [N_COEF];
  logic [OSIZE-1:0]        shd_o [N_OFFS];
  logic [OSIZE-1:0]        act_o [N_OFFS];
  logic signed [MSIZE-1:0] dec_m [N_COEF];
  logic signed [OSIZE-1:0] dec_o [N_OFFS];
  logic signed [MSIZE-1:0] s1_m  [N_COEF];
  logic signed [OSIZE-1:0] s1_o  [N_OFFS];
  logic [DSIZE-1:0]        s1_r, s1_g, s1_b;
  logic                    v1, v2, v3;
  logic                    sof1, sof2, sof3;
  logic [DSIZE-1:0]        res [N_CH];

  function automatic logic signed [MSIZE-1:0] sm_coef(input logic [MSIZE-1:0] v);
    logic signed [MSIZE-1:0] mag;
    mag = $signed({1'b0, v[MSIZE-2:0]});
    return v[MSIZE-1] ? -mag : mag;
  endfunction

  function automatic logic signed [OSIZE-1:0] sm_offs(input logic [OSIZE-1:0] v);
    logic signed [OSIZE-1:0] mag;
    mag = $signed({1'b0, v[OSIZE-2:0]});
    return v[OSIZE-1] ? -mag : mag;
  endfunction

  assign en          = m_ready | ~m_valid;
  assign s_ready     = en | ~rst_n;
  assign accept      = s_valid & en;
  assign transfer    = pending & accept & s_sof;
  assign cfg_pending = pending;

  // The frame-start pixel that triggers a transfer already sees the new set.
  always_comb begin
    for (int unsigned k = 0; k < N_COEF; k++) begin
      dec_m[k] = sm_coef(transfer ? shd_m[k] : act_m[k]);
    end
    for (int unsigned k = 0; k < N_OFFS; k++) begin
      dec_o[k] = sm_offs(transfer ? shd_o[k] : act_o[k]);
    end
  end

  // Shadow/active configuration and commit tracking
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < N_COEF; k++) begin
        shd_m[k] <= MSIZE'(identity_value(k, FRAC));
        act_m[k] <= MSIZE'(identity_value(k, FRAC));
      end
      for (int unsigned k = 0; k < N_OFFS; k++) begin
        shd_o[k] <= '0;
        act_o[k] <= '0;
      end
      pending <= 1'b0;
    end else begin
      if (transfer) begin
        act_m <= shd_m;
        act_o <= shd_o;
      end
      if (cfg_we) begin
        if (cfg_addr <= CFG_M22) begin
          shd_m[cfg_addr] <= cfg_wdata[MSIZE-1:0];
        end else if (cfg_addr <= CFG_O2) begin
          shd_o[offs_idx_t'(cfg_addr - CFG_O0)] <= cfg_wdata[OSIZE-1:0];
        end
      end
      if (transfer) begin
        pending <= 1'b0;
      end else if (cfg_commit) begin
        pending <= 1'b1;
      end
    end
  end

  // Valid and start-of-frame travel alongside the data through all four stages
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      m_valid <= 1'b0;
      sof1    <= 1'b0;
      sof2    <= 1'b0;
      sof3    <= 1'b0;
      m_sof   <= 1'b0;
    end else if (en) begin
      v1      <= s_valid;
      v2      <= v1;
      v3      <= v2;
      m_valid <= v3;
      sof1    <= s_sof;
      sof2    <= sof1;
      sof3    <= sof2;
      m_sof   <= sof3;
    end
  end

  // Stage 1: pixel and per-pixel snapshot of the decoded coefficient set
  always_ff @(posedge clk) begin
    if (en) begin
      s1_r <= iR;
      s1_g <= iG;
      s1_b <= iB;
      s1_m <= dec_m;
      s1_o <= dec_o;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    cm_channel #(
      .DSIZE(DSIZE),
      .MSIZE(MSIZE),
      .FRAC (FRAC),
      .OSIZE(OSIZE)
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (en),
      .x0   (s1_r),
      .x1   (s1_g),
      .x2   (s1_b),
      .c0   (s1_m[3*i]),
      .c1   (s1_m[3*i+1]),
      .c2   (s1_m[3*i+2]),
      .off  (s1_o[i]),
      .res  (res[i]),
      .ovf  (ovf[i])
    );
  end

  assign Ro = res[0];
  assign Go = res[1];
  assign Bo = res[2];

endmodule

// File: tb/tb_color_matrix_pipe.sv
// Self-checking bench: directed cases plus a random stalled stream against an arithmetic reference model.
module tb_color_matrix_pipe;

  localparam int unsigned DSIZE = 8;
  localparam int unsigned MSIZE = 9;
  localparam int unsigned FRAC  = 6;
  localparam int unsigned OSIZE = 10;
  localparam int unsigned CW    = 10;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             s_valid, s_ready, s_sof;
  logic [DSIZE-1:0] iR, iG, iB;
  logic             m_valid, m_ready, m_sof;
  logic [DSIZE-1:0] Ro, Go, Bo;
  logic [2:0]       ovf;
  logic             cfg_we, cfg_commit, cfg_pending;
  logic [3:0]       cfg_addr;
  logic [CW-1:0]    cfg_wdata;
  logic [27:0]      out_word;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          act_c [12];
  int          shd_c [12];
  bit          pend_m;
  logic [27:0] sb [$];
  logic [27:0] held_word;
  logic [27:0] last_out;
  bit          held_v;
  int          n_out = 0;
  int          last_lat;

  always #5 clk = ~clk;

  assign out_word = {m_sof, ovf, Bo, Go, Ro};

  color_matrix_pipe #(.DSIZE(DSIZE), .MSIZE(MSIZE), .FRAC(FRAC), .OSIZE(OSIZE)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof),
    .iR(iR), .iG(iG), .iB(iB), .m_valid(m_valid), .m_ready(m_ready), .m_sof(m_sof),
    .Ro(Ro), .Go(Go), .Bo(Bo), .ovf(ovf), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit), .cfg_pending(cfg_pending)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sm_val(input int code, input int w);
    int mag;
    mag = code & ((1 << (w - 1)) - 1);
    return ((code >> (w - 1)) & 1) != 0 ? -mag : mag;
  endfunction

  function automatic int floor_div(input int a, input int d);
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  // Expected {sof, ovf[2:0], B, G, R} for one pixel under configuration cfg
  function automatic logic [27:0] model(input int r, input int g, input int b, input bit sof,
                                        input int cfg [12]);
    int x [3];
    int acc, v;
    logic [27:0] w;
    x[0] = r; x[1] = g; x[2] = b;
    w = '0;
    w[27] = sof;
    for (int i = 0; i < 3; i++) begin
      acc = 0;
      for (int j = 0; j < 3; j++) acc += sm_val(cfg[3*i+j], MSIZE) * x[j];
      v = floor_div(acc + (1 << (FRAC - 1)), 1 << FRAC) + sm_val(cfg[9+i], OSIZE);
      if (v < 0) begin
        w[24+i] = 1'b1; v = 0;
      end else if (v > 255) begin
        w[24+i] = 1'b1; v = 255;
      end
      w[8*i +: 8] = 8'(v);
    end
    return w;
  endfunction

  task automatic reset_model();
    for (int k = 0; k < 12; k++) begin
      act_c[k] = (k == 0 || k == 4 || k == 8) ? 64 : 0;
      shd_c[k] = act_c[k];
    end
    pend_m = 1'b0;
    sb.delete();
    held_v = 1'b0;
  endtask

  // One clock: observe at negedge, update scoreboard/model, then step past the posedge
  task automatic cycle();
    bit acc_b, xfer;
    int use_c [12];
    logic [27:0] e;
    @(negedge clk);
    if (!rst_n) begin
      check("s_ready_in_reset", 32'(s_ready), 32'd1);
      reset_model();
    end else begin
      check("s_ready", 32'(s_ready), 32'(m_ready || !m_valid));
      check("cfg_pending", 32'(cfg_pending), 32'(pend_m));
      if (held_v) begin
        check("hold_valid", 32'(m_valid), 32'd1);
        check("hold_data", 32'(out_word), 32'(held_word));
      end
      if (m_valid && m_ready) begin
        check("out_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("out_pixel", 32'(out_word), 32'(e));
        end
        last_out = out_word;
        n_out++;
      end
      held_v    = m_valid && !m_ready;
      held_word = out_word;
      acc_b = s_valid && s_ready;
      xfer  = pend_m && acc_b && s_sof;
      if (xfer) use_c = shd_c; else use_c = act_c;
      if (acc_b) sb.push_back(model(int'(iR), int'(iG), int'(iB), s_sof, use_c));
      if (xfer) act_c = shd_c;
      if (cfg_we && cfg_addr < 9) shd_c[cfg_addr] = int'(cfg_wdata) & 511;
      else if (cfg_we && cfg_addr < 12) shd_c[cfg_addr] = int'(cfg_wdata) & 1023;
      if (xfer) pend_m = 1'b0;
      else if (cfg_commit) pend_m = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int addr, input int data);
    cfg_we = 1'b1; cfg_addr = 4'(addr); cfg_wdata = CW'(data);
    cycle();
    cfg_we = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    cycle();
    cfg_commit = 1'b0;
  endtask

  task automatic send_px(input int r, input int g, input int b, input bit sof, input bit cmt);
    int n0;
    s_valid = 1'b1; iR = 8'(r); iG = 8'(g); iB = 8'(b); s_sof = sof; cfg_commit = cmt;
    cycle();
    s_valid = 1'b0; s_sof = 1'b0; cfg_commit = 1'b0;
    n0 = n_out;
    last_lat = 0;
    while (n_out == n0 && last_lat < 20) begin
      cycle();
      last_lat++;
    end
    check("px_timeout", 32'(n_out != n0), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_sof = 1'b0; iR = '0; iG = '0; iB = '0;
    m_ready = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; cfg_commit = 1'b0;
    reset_model();
    repeat (3) cycle();
    check("reset_outputs", 32'({m_valid, out_word}), 32'd0);
    check("reset_pending", 32'(cfg_pending), 32'd0);
    rst_n = 1'b1;
    cycle();

    // Identity pass-through and latency
    send_px(10, 128, 255, 1'b1, 1'b0);
    check("latency", 32'(last_lat), 32'd4);
    check("identity_px", 32'(last_out), 32'({1'b1, 3'b000, 8'd255, 8'd128, 8'd10}));

    // Gain 2.0 saturates high; gain -1.0 saturates low
    cfg_write(0, 128);
    commit();
    send_px(200, 7, 9, 1'b1, 1'b0);
    check("gain2_ro", 32'(last_out[7:0]), 32'd255);
    check("gain2_ovf", 32'(last_out[26:24]), 32'b001);
    check("gain2_gb", 32'(last_out[23:8]), 32'({8'd9, 8'd7}));
    cfg_write(0, 256 + 64);
    commit();
    send_px(50, 0, 0, 1'b1, 1'b0);
    check("neg_ro", 32'(last_out[7:0]), 32'd0);
    check("neg_ovf0", 32'(last_out[24]), 32'd1);

    // Gain 0.5 rounds half up; negative-zero coefficient contributes nothing
    cfg_write(0, 32);
    cfg_write(1, 256);
    commit();
    send_px(3, 200, 0, 1'b1, 1'b0);
    check("half_ro", 32'(last_out[7:0]), 32'd2);
    check("half_ovf0", 32'(last_out[24]), 32'd0);
    cfg_write(9, 512 + 5);
    commit();
    send_px(3, 200, 0, 1'b1, 1'b0);
    check("offs_ro", 32'(last_out[7:0]), 32'd0);
    check("offs_ovf0", 32'(last_out[24]), 32'd1);

    // Restore identity row 0
    cfg_write(0, 64);
    cfg_write(1, 0);
    cfg_write(9, 0);
    commit();
    send_px(1, 2, 3, 1'b1, 1'b0);
    check("restore_px", 32'(last_out), 32'({1'b1, 3'b000, 8'd3, 8'd2, 8'd1}));

    // Mid-frame commit waits for the next frame start
    cfg_write(0, 128);
    commit();
    check("pending_set", 32'(cfg_pending), 32'd1);
    send_px(100, 0, 0, 1'b0, 1'b0);
    check("midframe_old_ro", 32'(last_out[7:0]), 32'd100);
    check("pending_held", 32'(cfg_pending), 32'd1);
    send_px(100, 0, 0, 1'b1, 1'b0);
    check("sof_new_ro", 32'(last_out[7:0]), 32'd200);
    check("pending_clear", 32'(cfg_pending), 32'd0);

    // Commit coinciding with a frame start applies only at the following one
    cfg_write(0, 64);
    send_px(50, 0, 0, 1'b1, 1'b1);
    check("same_cycle_old", 32'(last_out[7:0]), 32'd100);
    send_px(50, 0, 0, 1'b1, 1'b0);
    check("same_cycle_next", 32'(last_out[7:0]), 32'd50);

    // Random stream with random stalls, config writes and commits
    for (int t = 0; t < 300; t++) begin
      s_valid = ($urandom_range(0, 4) != 0);
      iR = 8'($urandom); iG = 8'($urandom); iB = 8'($urandom);
      s_sof = ($urandom_range(0, 15) == 0);
      m_ready = (t >= 100 && t < 103) ? 1'b0 : ($urandom_range(0, 3) != 0);
      cfg_we = ($urandom_range(0, 7) == 0);
      cfg_addr = 4'($urandom_range(0, 15));
      if (cfg_addr < 9) cfg_wdata = CW'($urandom_range(0, 1) * 256 + $urandom_range(0, 96));
      else cfg_wdata = CW'($urandom_range(0, 1) * 512 + $urandom_range(0, 200));
      cfg_commit = ($urandom_range(0, 19) == 0);
      cycle();
    end
    s_valid = 1'b0; s_sof = 1'b0; cfg_we = 1'b0; cfg_commit = 1'b0; m_ready = 1'b1;
    for (int k = 0; k < 40 && sb.size() != 0; k++) cycle();
    check("drain_empty", 32'(sb.size()), 32'd0);

    // Reset with pixels in flight and a pending commit
    cfg_write(0, 128);
    commit();
    s_valid = 1'b1; iR = 8'd20; iG = 8'd30; iB = 8'd40;
    repeat (3) cycle();
    s_valid = 1'b0;
    m_ready = 1'b0;
    rst_n = 1'b0;
    cycle();
    check("rst_mvalid", 32'(m_valid), 32'd0);
    check("rst_pending", 32'(cfg_pending), 32'd0);
    check("rst_outputs", 32'(out_word), 32'd0);
    rst_n = 1'b1;
    m_ready = 1'b1;
    cycle();
    send_px(10, 128, 255, 1'b0, 1'b0);
    check("rst_identity", 32'(last_out), 32'({1'b0, 3'b000, 8'd255, 8'd128, 8'd10}));
    commit();
    send_px(10, 128, 255, 1'b1, 1'b0);
    check("rst_shadow_identity", 32'(last_out), 32'({1'b1, 3'b000, 8'd255, 8'd128, 8'd10}));
    repeat (3) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
